payload_nfa_engine: RTL and testbench

PAYLOAD_NFA_ENGINE -- requirements
Module: payload_nfa_engine

---
 rtl/payload_nfa_engine.sv | 163 ++++++++++++++++
 tb/tb_payload_nfa_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_nfa_engine.sv
// payload_nfa_engine
//   Parallel (Glushkov-style) NFA matcher for one payload. Each state flop
//   is gated by one bit of the character-class decode bus. A state is fed
//   from its predecessor, from an optional self-loop, and from an optional
//   skip edge two states back. Anchoring can restrict where a match may
//   begin. The last state flags an accepting byte.
//
// Ports
//   clk          : clock, all updates on the rising edge
//   sod          : start of data, asynchronous active-high clear of the block
//   en           : byte-valid qualifier
//   in_class     : class-decode hits for the current byte
//   eod          : current enabled byte is the last of the payload
//   out          : sticky match flag
//   match_offset : byte index of the first accepting byte
//   match_count  : number of accepting bytes (saturating)
//   done         : payload finished, results are final
module payload_nfa_engine #(
  parameter int unsigned                 NUM_STATES  = 18,
  parameter int unsigned                 NUM_CLASSES = 32,
  parameter logic [NUM_STATES*8-1:0]     CLASS_SEL   = '0,
  parameter logic [NUM_STATES-1:0]       LOOP_MASK   = '0,
  parameter logic [NUM_STATES-1:0]       SKIP_MASK   = '0,
  parameter int unsigned                 ANCHOR_MODE = 0,
  parameter int unsigned                 NL_CLASS    = 0,
  parameter int unsigned                 CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   sod,
  input  logic                   en,
  input  logic [NUM_CLASSES-1:0] in_class,
  input  logic                   eod,
  output logic                   out,
  output logic [CNT_W-1:0]       match_offset,
  output logic [CNT_W-1:0]       match_count,
  output logic                   done
);

  localparam logic [7:0] NL_IDX = 8'(NL_CLASS);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  logic [255:0]            class_ext;
  logic [NUM_STATES-1:0]   cls;
  logic [NUM_STATES-1:0]   s_q;
  logic [NUM_STATES-1:0]   pred;
  logic [NUM_STATES-1:0]   s_next;
  logic                    arm;
  logic                    hit;
  logic                    accept;
  logic                    nl_prev;
  logic [CNT_W-1:0]        byte_cnt;

  // ---------------------------------------------------------------------------
  // Payload FSM: running until an accepted byte carries eod, then frozen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (en && eod) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    done   = (state_q == ST_DONE);
    accept = en && (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // Class decode. The bus is zero-extended to 256 bits so an 8-bit selector
  // always indexes in range, whatever NUM_CLASSES is.
  // ---------------------------------------------------------------------------
  always_comb begin
    class_ext                    = '0;
    class_ext[NUM_CLASSES-1:0]   = in_class;
  end

  always_comb begin
    cls = '0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      cls[i] = class_ext[CLASS_SEL[i*8 +: 8]];
    end
  end

  // ---------------------------------------------------------------------------
  // Anchoring
  // ---------------------------------------------------------------------------
  always_comb begin
    case (ANCHOR_MODE)
      0:       arm = 1'b1;
      1:       arm = (byte_cnt == '0);
      2:       arm = (byte_cnt == '0) || nl_prev;
      default: arm = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // NFA transition. Predecessor, self-loop and skip edges are formed as whole
  // vector shifts; the shifts leave bit 0 (and bits 0..1 for skip) empty, so
  // the arm term lands only on state 0 and skip bits 0/1 have no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    pred   = (s_q << 1)
           | NUM_STATES'(arm)
           | (LOOP_MASK & s_q)
           | (SKIP_MASK & (s_q << 2));
    s_next = cls & pred;
    hit    = s_next[NUM_STATES-1];
  end

  // ---------------------------------------------------------------------------
  // State flops, byte index and newline history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      s_q      <= '0;
      nl_prev  <= 1'b0;
      byte_cnt <= '0;
    end else if (accept) begin
      s_q     <= s_next;
      nl_prev <= class_ext[NL_IDX];
      if (byte_cnt != '1) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Match results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      out          <= 1'b0;
      match_offset <= '0;
      match_count  <= '0;
    end else if (accept && hit) begin
      out <= 1'b1;
      if (!out) begin
        match_offset <= byte_cnt;
      end
      if (match_count != '1) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_payload_nfa_engine.sv
// Testbench for payload_nfa_engine. Five instances share one byte stream:
// pattern a b+ c in anchor modes 0/1/2, an a b? c skip variant, and a
// 3-bit counter variant. Expectations come from a regex-level model over
// the list of accepted bytes.
module tb_payload_nfa_engine;

  typedef byte bq_t[$];

  logic        clk;
  logic        sod;
  logic        en;
  logic [31:0] in_class;
  logic        eod;

  logic        out_m0, out_m1, out_m2, out_sk, out_c3;
  logic [15:0] off_m0, off_m1, off_m2, off_sk;
  logic [15:0] cnt_m0, cnt_m1, cnt_m2, cnt_sk;
  logic [2:0]  off_c3, cnt_c3;
  logic        done_m0, done_m1, done_m2, done_sk, done_c3;

  int checks;
  int failures;

  byte acc[$];
  bit  mdone;

  localparam logic [23:0] SEL = {8'd2, 8'd1, 8'd0};

  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(32), .CLASS_SEL(SEL),
    .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR_MODE(0), .NL_CLASS(3), .CNT_W(16))
  u_m0 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod),
    .out(out_m0), .match_offset(off_m0), .match_count(cnt_m0), .done(done_m0));

  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(32), .CLASS_SEL(SEL),
    .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR_MODE(1), .NL_CLASS(3), .CNT_W(16))
  u_m1 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod),
    .out(out_m1), .match_offset(off_m1), .match_count(cnt_m1), .done(done_m1));

  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(32), .CLASS_SEL(SEL),
    .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR_MODE(2), .NL_CLASS(3), .CNT_W(16))
  u_m2 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod),
    .out(out_m2), .match_offset(off_m2), .match_count(cnt_m2), .done(done_m2));

  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(32), .CLASS_SEL(SEL),
    .LOOP_MASK(3'b000), .SKIP_MASK(3'b100), .ANCHOR_MODE(0), .NL_CLASS(3), .CNT_W(16))
  u_sk (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod),
    .out(out_sk), .match_offset(off_sk), .match_count(cnt_sk), .done(done_sk));

  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(32), .CLASS_SEL(SEL),
    .LOOP_MASK(3'b010), .SKIP_MASK(3'b000), .ANCHOR_MODE(0), .NL_CLASS(3), .CNT_W(3))
  u_c3 (.clk(clk), .sod(sod), .en(en), .in_class(in_class), .eod(eod),
    .out(out_c3), .match_offset(off_c3), .match_count(cnt_c3), .done(done_c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] class_of(input byte ch);
    logic [31:0] c;
    c = '0;
    case (ch)
      "a":     c[0] = 1'b1;
      "b":     c[1] = 1'b1;
      "c":     c[2] = 1'b1;
      "\n":    c[3] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic byte rand_char();
    case ($urandom_range(5))
      0, 1:    return "a";
      2, 3:    return "b";
      4:       return "c";
      default: return ($urandom_range(1) == 0) ? "x" : "\n";
    endcase
  endfunction

  // A match ends at byte k if some anchor-eligible start j begins a string
  // of the language (a b+ c, or a b? c for the skip variant) ending at k.
  function automatic bit hit_at(input int k, input int mode, input bit skipv);
    for (int j = 0; j <= k; j++) begin
      bit armd;
      armd = (mode == 0) || (j == 0) || (mode == 2 && acc[j-1] == "\n");
      if (!armd || acc[j] != "a" || acc[k] != "c") continue;
      if (skipv) begin
        if ((k - j == 1) || (k - j == 2 && acc[j+1] == "b")) return 1'b1;
      end else if (k - j >= 2) begin
        bit allb;
        allb = 1'b1;
        for (int m = j + 1; m < k; m++) if (acc[m] != "b") allb = 1'b0;
        if (allb) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_dut(input string name, input int mode, input bit skipv, input int w,
                           input logic o, input logic [15:0] off, input logic [15:0] cnt,
                           input logic d);
    int sat, e_cnt, e_off;
    bit e_out;
    sat   = (1 << w) - 1;
    e_cnt = 0;
    e_off = 0;
    e_out = 1'b0;
    for (int k = 0; k < acc.size(); k++) begin
      if (hit_at(k, mode, skipv)) begin
        if (!e_out) e_off = (k > sat) ? sat : k;
        e_out = 1'b1;
        if (e_cnt < sat) e_cnt++;
      end
    end
    check({name, "_out"},  32'(o),   32'(e_out));
    check({name, "_off"},  32'(off), 32'(e_off));
    check({name, "_cnt"},  32'(cnt), 32'(e_cnt));
    check({name, "_done"}, 32'(d),   32'(mdone));
  endtask

  task automatic check_all();
    check_dut("m0", 0, 1'b0, 16, out_m0, off_m0, cnt_m0, done_m0);
    check_dut("m1", 1, 1'b0, 16, out_m1, off_m1, cnt_m1, done_m1);
    check_dut("m2", 2, 1'b0, 16, out_m2, off_m2, cnt_m2, done_m2);
    check_dut("sk", 0, 1'b1, 16, out_sk, off_sk, cnt_sk, done_sk);
    check_dut("c3", 0, 1'b0, 3,  out_c3, 16'(off_c3), 16'(cnt_c3), done_c3);
  endtask

  // sod pulse, optionally with a live byte on the same edge (sod must win).
  task automatic do_sod();
    @(negedge clk);
    sod      = 1'b1;
    en       = 1'($urandom_range(1));
    in_class = class_of("c");
    eod      = 1'($urandom_range(1));
    #1;
    check("sod_async_out", 32'(out_m0 | out_sk | done_m0), 32'd0);
    @(negedge clk);
    sod = 1'b0;
    en  = 1'b0;
    eod = 1'b0;
    acc.delete();
    mdone = 1'b0;
  endtask

  // Drive one payload; gap_pct inserts 1-3 idle cycles (random in_class/eod)
  // before bytes, extra sends ignored bytes after eod.
  task automatic run_payload(input bq_t p, input bit with_eod, input int gap_pct, input int extra);
    for (int i = 0; i < p.size(); i++) begin
      if ($urandom_range(99) < gap_pct) begin
        int g;
        g = $urandom_range(3, 1);
        for (int n = 0; n < g; n++) begin
          @(negedge clk);
          en       = 1'b0;
          in_class = $urandom();
          eod      = 1'($urandom_range(1));
        end
      end
      @(negedge clk);
      en       = 1'b1;
      in_class = class_of(p[i]);
      eod      = with_eod && (i == p.size() - 1);
      if (!mdone) begin
        acc.push_back(p[i]);
        if (eod) mdone = 1'b1;
      end
    end
    if (with_eod) begin
      for (int n = 0; n < extra; n++) begin
        @(negedge clk);
        en       = 1'b1;
        in_class = class_of(rand_char());
        eod      = 1'($urandom_range(1));
      end
    end
    @(negedge clk);
    en  = 1'b0;
    eod = 1'b0;
  endtask

  initial begin
    bq_t q;
    checks   = 0;
    failures = 0;
    mdone    = 1'b0;
    sod      = 1'b1;
    en       = 1'b0;
    eod      = 1'b0;
    in_class = '0;
    repeat (2) @(negedge clk);
    sod = 1'b0;
    @(negedge clk);
    check_all();

    run_payload(to_q("xabbbc"), 1'b1, 0, 0);
    check_all();
    check("req35_off", 32'(off_m0), 32'd5);
    check("req35_done", 32'(done_m0), 32'd1);

    do_sod();
    run_payload(to_q("xabc"), 1'b1, 0, 0);
    check_all();
    check("req36_m1_out", 32'(out_m1), 32'd0);

    do_sod();
    run_payload(to_q("abc"), 1'b1, 0, 0);
    check_all();
    check("req36_m1_off", 32'(off_m1), 32'd2);

    do_sod();
    run_payload(to_q("xa\nabc"), 1'b1, 0, 0);
    check_all();
    check("req37_m2_off", 32'(off_m2), 32'd5);
    check("req37_m1_out", 32'(out_m1), 32'd0);

    do_sod();
    run_payload(to_q("abcabbc"), 1'b1, 100, 0);
    check_all();
    check("req38_cnt", 32'(cnt_m0), 32'd2);

    do_sod();
    run_payload(to_q("ab"), 1'b0, 0, 0);
    check_all();
    do_sod();
    check_all();
    run_payload(to_q("abc"), 1'b1, 0, 0);
    check_all();
    check("req38_restart_off", 32'(off_m0), 32'd2);

    do_sod();
    run_payload(to_q("ac"), 1'b1, 0, 4);
    check_all();
    check("req39_sk_off", 32'(off_sk), 32'd1);

    do_sod();
    run_payload(to_q("abcabcabcabcabcabcabcabcabc"), 1'b1, 20, 2);
    check_all();
    check("req39_sat", 32'(cnt_c3), 32'd7);

    do_sod();
    run_payload(to_q("abcab"), 1'b0, 30, 0);
    check_all();
    check("no_eod_done", 32'(done_m0), 32'd0);

    for (int t = 0; t < 40; t++) begin
      do_sod();
      q.delete();
      for (int n = 0; n < int'($urandom_range(20, 1)); n++) q.push_back(rand_char());
      run_payload(q, 1'($urandom_range(3) != 0), 25, int'($urandom_range(3)));
      check_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
